utlb: RTL and testbench

Parametrised micro-TLB placed between a pipeline stage (instruction fetch or load/store) and the shared joint TLB (JTLB). It holds `ENTRIES` fully associative 4 KiB translations, each tagged with an ASID and a global bit. Lookups are combinational; misses are refilled from the JTLB through a two-phase fill handshake. It adds ASID tagging, global-page support, flush-all and flush-by-ASID, and a round-robin victim pointer that prefers invalid slots.

---
 rtl/utlb.sv | 166 ++++++++++++++++
 tb/tb_utlb.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/utlb.sv
`default_nettype none
// ============================================================================
//  Module   : utlb
//  Purpose  : Fully associative micro-TLB between a pipeline stage and the
//             joint TLB. It holds ENTRIES 4 KiB translations, each tagged with
//             an ASID and a global bit. Lookup is purely combinational. Misses
//             are refilled from the JTLB through a two-phase (phi2/phi1/phi2)
//             fill pipeline. Victims are the lowest invalid slot, otherwise a
//             round-robin pointer. Supports flush-all and flush-by-ASID.
//  Ports    :
//    clk, rst          clock; asynchronous active-high reset
//    phi1, phi2        mutually exclusive phase enables qualifying clk edges
//    va, asid, req     lookup address / ASID; req = lookup consumed this phase
//    pa, miss, cache   lookup result (pa/cache are zero on a miss)
//    fill, busy        refill request / refill in flight
//    flush, flushasid  invalidate all / invalidate non-global entries of asid
//    jtlbpa, jtlbcache, jtlbglobal       JTLB translation result
//    jtlbmiss, jtlbade, jtlbinval        JTLB faults (any one aborts refill)
//  Revision : 1.0  initial release
// ============================================================================
module utlb #(
  parameter int ENTRIES = 4,
  parameter int ASIDW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phi1,
  input  logic             phi2,
  input  logic [63:0]      va,
  input  logic [ASIDW-1:0] asid,
  input  logic             req,
  output logic [31:0]      pa,
  output logic             miss,
  output logic             cache,
  input  logic             fill,
  output logic             busy,
  input  logic             flush,
  input  logic             flushasid,
  input  logic [31:0]      jtlbpa,
  input  logic             jtlbcache,
  input  logic             jtlbglobal,
  input  logic             jtlbmiss,
  input  logic             jtlbade,
  input  logic             jtlbinval
);

  localparam int IDXW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IDXW-1:0] C_LAST = IDXW'(ENTRIES - 1);

  // --------------------------------------------------------------------------
  // Entry storage. Only the valid bits need reset; the payload is qualified
  // by valid everywhere it is used.
  // --------------------------------------------------------------------------
  logic [ENTRIES-1:0] r_valid;
  logic [51:0]        r_tag    [ENTRIES];
  logic [ASIDW-1:0]   r_easid  [ENTRIES];
  logic               r_glob   [ENTRIES];
  logic [19:0]        r_ppn    [ENTRIES];
  logic               r_cached [ENTRIES];

  logic [IDXW-1:0]    r_rr;
  logic               r_f0;
  logic               r_f1;

  logic [ENTRIES-1:0] w_hit;
  logic [ENTRIES-1:0] w_asid_kill;
  logic               w_hit_any;
  logic [IDXW-1:0]    w_hit_idx;
  logic               w_inv_any;
  logic [IDXW-1:0]    w_inv_idx;
  logic [IDXW-1:0]    w_victim;
  logic [IDXW-1:0]    w_rr_next;
  logic               w_cancel;
  logic               w_fault;
  logic               w_write;
  logic               w_req_adv;
  logic               w_rr_adv;

  // --------------------------------------------------------------------------
  // Per-entry match and flush-by-ASID select
  // --------------------------------------------------------------------------
  always_comb begin
    w_hit       = '0;
    w_asid_kill = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_hit[i]       = r_valid[i] && (va[63:12] == r_tag[i]) &&
                       (r_glob[i] || (r_easid[i] == asid));
      w_asid_kill[i] = !r_glob[i] && (r_easid[i] == asid);
    end
  end

  // Lowest-index hit wins; multiple hits are a software error, this merely
  // keeps the output deterministic.
  always_comb begin
    w_hit_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_hit_idx = IDXW'(i);
    end
  end

  assign w_hit_any = |w_hit;

  // Lowest-index invalid slot, used as victim in preference to rr.
  always_comb begin
    w_inv_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_inv_idx = IDXW'(i);
    end
  end

  assign w_inv_any = ~&r_valid;
  assign w_victim  = w_inv_any ? w_inv_idx : r_rr;
  assign w_rr_next = (r_rr == C_LAST) ? '0 : r_rr + IDXW'(1);

  // --------------------------------------------------------------------------
  // Phase-2 action priority: flush > flushasid > refill write > req update.
  // Any pending refill (r_f0) owns this phi2, even when a fault discards it,
  // so a req hit in that phase never moves rr.
  // --------------------------------------------------------------------------
  assign w_cancel  = flush | flushasid;
  assign w_fault   = jtlbmiss | jtlbade | jtlbinval;
  assign w_write   = phi2 & r_f0 & ~w_cancel & ~w_fault;
  assign w_req_adv = phi2 & ~w_cancel & ~r_f0 & req & w_hit_any &
                     (w_hit_idx == r_rr);
  assign w_rr_adv  = (w_write & (w_victim == r_rr)) | w_req_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_rr    <= '0;
      r_f0    <= 1'b0;
      r_f1    <= 1'b0;
    end else begin
      if (phi2) r_f0 <= fill & ~w_cancel;
      if (phi1) r_f1 <= r_f0;
      if (w_rr_adv) r_rr <= w_rr_next;
      if (phi2 && flush) begin
        r_valid <= '0;
      end else if (phi2 && flushasid) begin
        r_valid <= r_valid & ~w_asid_kill;
      end else if (w_write) begin
        r_valid[w_victim] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_tag[w_victim]    <= va[63:12];
      r_easid[w_victim]  <= asid;
      r_glob[w_victim]   <= jtlbglobal;
      r_ppn[w_victim]    <= jtlbpa[31:12];
      r_cached[w_victim] <= jtlbcache;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign miss  = ~w_hit_any;
  assign pa    = w_hit_any ? {r_ppn[w_hit_idx], va[11:0]} : 32'h0;
  assign cache = w_hit_any & r_cached[w_hit_idx];
  assign busy  = r_f0 | r_f1;

endmodule
`default_nettype wire

// File: tb/tb_utlb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_utlb
//  Purpose  : Directed self-checking bench for utlb (ENTRIES=4, ASIDW=8).
//             Phases are driven one clk edge at a time; outputs are sampled
//             1 time unit after the active edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_utlb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phi1 = 1'b0, phi2 = 1'b0;
  logic [63:0] va = '0;
  logic [7:0]  asid = '0;
  logic        req = 1'b0;
  logic [31:0] pa;
  logic        miss, cache, busy;
  logic        fill = 1'b0, flush = 1'b0, flushasid = 1'b0;
  logic [31:0] jtlbpa = '0;
  logic        jtlbcache = 1'b0, jtlbglobal = 1'b0;
  logic        jtlbmiss = 1'b0, jtlbade = 1'b0, jtlbinval = 1'b0;

  int checks = 0;
  int errors = 0;

  utlb #(.ENTRIES(4), .ASIDW(8)) dut (
    .clk(clk), .rst(rst), .phi1(phi1), .phi2(phi2),
    .va(va), .asid(asid), .req(req),
    .pa(pa), .miss(miss), .cache(cache),
    .fill(fill), .busy(busy), .flush(flush), .flushasid(flushasid),
    .jtlbpa(jtlbpa), .jtlbcache(jtlbcache), .jtlbglobal(jtlbglobal),
    .jtlbmiss(jtlbmiss), .jtlbade(jtlbade), .jtlbinval(jtlbinval)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clk edge with the given phase enables.
  task automatic step(input logic p1, input logic p2);
    @(negedge clk);
    phi1 = p1;
    phi2 = p2;
    @(posedge clk);
    #1;
    phi1 = 1'b0;
    phi2 = 1'b0;
  endtask

  task automatic look(input string tag, input logic [63:0] v, input logic [7:0] a,
                      input logic emiss, input logic [31:0] epa, input logic ecache);
    va   = v;
    asid = a;
    #1;
    chk({tag, "_miss"}, miss, emiss);
    chk({tag, "_pa"}, pa, epa);
    chk({tag, "_cache"}, cache, ecache);
  endtask

  // Full refill: fill at phi2 n, write at phi2 n+1, busy falls at next phi1.
  task automatic refill(input string tag, input logic [63:0] v, input logic [7:0] a,
                        input logic [31:0] p, input logic c, input logic g,
                        input logic [2:0] flt);
    va = v; asid = a; jtlbpa = p; jtlbcache = c; jtlbglobal = g;
    {jtlbmiss, jtlbade, jtlbinval} = flt;
    fill = 1'b1;
    step(1'b0, 1'b1);
    fill = 1'b0;
    chk({tag, "_busy_a"}, busy, 1'b1);
    step(1'b0, 1'b0);
    chk({tag, "_busy_idle"}, busy, 1'b1);
    step(1'b1, 1'b0);
    chk({tag, "_busy_b"}, busy, 1'b1);
    step(1'b0, 1'b1);
    chk({tag, "_busy_c"}, busy, 1'b1);
    step(1'b1, 1'b0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    {jtlbmiss, jtlbade, jtlbinval} = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);
  endtask

  initial begin
    // ---------------- Reset state ----------------
    step(1'b0, 1'b0);
    chk("rst_miss", miss, 1'b1);
    chk("rst_pa", pa, 32'h0);
    chk("rst_cache", cache, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0);

    // ---------------- Basic refill ----------------
    look("basic_pre", 64'h1234, 8'd3, 1'b1, 32'h0, 1'b0);
    chk("basic_pre_busy", busy, 1'b0);
    refill("basic", 64'h1234, 8'd3, 32'h0ABCD000, 1'b1, 1'b0, 3'b000);
    look("basic_hit", 64'h1234, 8'd3, 1'b0, 32'h0ABCD234, 1'b1);

    // ---------------- ASID tagging ----------------
    look("asid_other", 64'h1234, 8'd4, 1'b1, 32'h0, 1'b0);
    refill("glob", 64'h5678, 8'd3, 32'h00011000, 1'b0, 1'b1, 3'b000);
    look("glob_asid4", 64'h5678, 8'd4, 1'b0, 32'h00011678, 1'b0);

    // ---------------- Replacement ----------------
    do_reset();
    refill("p1", 64'h1000, 8'd1, 32'hA0001000, 1'b0, 1'b0, 3'b000);
    refill("p2", 64'h2000, 8'd1, 32'hA0002000, 1'b1, 1'b0, 3'b000);
    refill("p3", 64'h3000, 8'd1, 32'hA0003000, 1'b0, 1'b0, 3'b000);
    refill("p4", 64'h4000, 8'd1, 32'hA0004000, 1'b0, 1'b0, 3'b000);
    look("p1_hit", 64'h1ABC, 8'd1, 1'b0, 32'hA0001ABC, 1'b0);
    look("p2_hit", 64'h2ABC, 8'd1, 1'b0, 32'hA0002ABC, 1'b1);
    look("p3_hit", 64'h3ABC, 8'd1, 1'b0, 32'hA0003ABC, 1'b0);
    look("p4_hit", 64'h4ABC, 8'd1, 1'b0, 32'hA0004ABC, 1'b0);
    // All valid, rr=0: p5 evicts slot 0 (p1), rr -> 1.
    refill("p5", 64'hFFFF_0000_0000_5000, 8'd1, 32'hA0005000, 1'b0, 1'b0, 3'b000);
    look("p1_evicted", 64'h1ABC, 8'd1, 1'b1, 32'h0, 1'b0);
    look("p5_hit", 64'hFFFF_0000_0000_5ABC, 8'd1, 1'b0, 32'hA0005ABC, 1'b0);
    look("p5_lowtag", 64'h5ABC, 8'd1, 1'b1, 32'h0, 1'b0);
    // req hit on slot 3 (not rr) leaves rr=1: p6 evicts slot 1 (p2), rr -> 2.
    va = 64'h4000; req = 1'b1;
    step(1'b0, 1'b1);
    req = 1'b0;
    refill("p6", 64'h6000, 8'd1, 32'hA0006000, 1'b0, 1'b0, 3'b000);
    look("p2_evicted", 64'h2000, 8'd1, 1'b1, 32'h0, 1'b0);
    look("p6_hit", 64'h6000, 8'd1, 1'b0, 32'hA0006000, 1'b0);
    look("p4_kept", 64'h4000, 8'd1, 1'b0, 32'hA0004000, 1'b0);
    // req hit on slot 2 (== rr) advances rr to 3: p7 evicts slot 3 (p4), rr -> 0.
    va = 64'h3000; req = 1'b1;
    step(1'b0, 1'b1);
    req = 1'b0;
    refill("p7", 64'h7000, 8'd1, 32'hA0007000, 1'b0, 1'b0, 3'b000);
    look("p4_evicted", 64'h4000, 8'd1, 1'b1, 32'h0, 1'b0);
    look("p7_hit", 64'h7000, 8'd1, 1'b0, 32'hA0007000, 1'b0);
    look("p3_kept", 64'h3000, 8'd1, 1'b0, 32'hA0003000, 1'b0);

    // ---------------- Faults: nothing written, rr held at 0 ----------------
    refill("f_miss", 64'h8000, 8'd1, 32'hA0008000, 1'b0, 1'b0, 3'b100);
    look("f_miss_lk", 64'h8000, 8'd1, 1'b1, 32'h0, 1'b0);
    refill("f_ade", 64'h8000, 8'd1, 32'hA0008000, 1'b0, 1'b0, 3'b010);
    look("f_ade_lk", 64'h8000, 8'd1, 1'b1, 32'h0, 1'b0);
    refill("f_inval", 64'h8000, 8'd1, 32'hA0008000, 1'b0, 1'b0, 3'b001);
    look("f_inval_lk", 64'h8000, 8'd1, 1'b1, 32'h0, 1'b0);
    refill("p9", 64'h9000, 8'd1, 32'hA0009000, 1'b0, 1'b0, 3'b000);
    look("p5_evicted", 64'hFFFF_0000_0000_5000, 8'd1, 1'b1, 32'h0, 1'b0);
    look("p9_hit", 64'h9000, 8'd1, 1'b0, 32'hA0009000, 1'b0);
    look("p7_kept", 64'h7000, 8'd1, 1'b0, 32'hA0007000, 1'b0);
    look("p6_kept", 64'h6000, 8'd1, 1'b0, 32'hA0006000, 1'b0);

    // ---------------- flushasid ----------------
    do_reset();
    refill("x", 64'h1000, 8'd3, 32'hB0001000, 1'b0, 1'b0, 3'b000);
    refill("y", 64'h2000, 8'd3, 32'hB0002000, 1'b1, 1'b1, 3'b000);
    refill("z", 64'h3000, 8'd5, 32'hB0003000, 1'b0, 1'b0, 3'b000);
    asid = 8'd3; flushasid = 1'b1;
    step(1'b0, 1'b1);
    flushasid = 1'b0;
    look("fa_x", 64'h1000, 8'd3, 1'b1, 32'h0, 1'b0);
    look("fa_y3", 64'h2000, 8'd3, 1'b0, 32'hB0002000, 1'b1);
    look("fa_y5", 64'h2010, 8'd5, 1'b0, 32'hB0002010, 1'b1);
    look("fa_z5", 64'h3000, 8'd5, 1'b0, 32'hB0003000, 1'b0);

    // ---------------- flush on the refill write phase ----------------
    va = 64'h4000; asid = 8'd5; jtlbpa = 32'hB0004000; jtlbglobal = 1'b0;
    fill = 1'b1;
    step(1'b0, 1'b1);
    fill = 1'b0;
    step(1'b1, 1'b0);
    flush = 1'b1;
    step(1'b0, 1'b1);
    flush = 1'b0;
    chk("fl_busy_a", busy, 1'b1);
    step(1'b1, 1'b0);
    chk("fl_busy_end", busy, 1'b0);
    look("fl_w", 64'h4000, 8'd5, 1'b1, 32'h0, 1'b0);
    look("fl_y", 64'h2000, 8'd3, 1'b1, 32'h0, 1'b0);
    look("fl_z", 64'h3000, 8'd5, 1'b1, 32'h0, 1'b0);

    // ---------------- asynchronous reset mid-refill ----------------
    refill("v", 64'h6000, 8'd2, 32'h0CAFE000, 1'b1, 1'b0, 3'b000);
    look("v_hit", 64'h6123, 8'd2, 1'b0, 32'h0CAFE123, 1'b1);
    va = 64'h7000; asid = 8'd2; jtlbpa = 32'h0BEEF000;
    fill = 1'b1;
    step(1'b0, 1'b1);
    fill = 1'b0;
    step(1'b1, 1'b0);
    chk("ar_busy_pre", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_busy", busy, 1'b0);
    look("ar_v", 64'h6123, 8'd2, 1'b1, 32'h0, 1'b0);
    rst = 1'b0;
    va = 64'h7000;
    step(1'b0, 1'b1);
    look("ar_w", 64'h7000, 8'd2, 1'b1, 32'h0, 1'b0);
    chk("ar_busy_post", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
